// File: rtl/rv32i_types.sv
// Shared types for the branch target buffer.
//   ctr_e        : 2-bit saturating direction counter encodings
//   btb_entry_t  : one BTB entry (valid, tag, target, ctr)
// Tag and target fields are sized for the widest supported XLEN (64). Narrower
// configurations zero-extend into them, and synthesis trims the constant upper bits.
package rv32i_types;

    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned TAG_MAX  = 64;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_MAX-1:0]  tag;
        logic [XLEN_MAX-1:0] target;
        ctr_e                ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
//   ctr_i      : current counter value
//   taken_i    : resolved outcome (1 = count up, 0 = count down)
//   ctr_next_o : combinational next value, saturating at STRONG_NT / STRONG_T
module sat_counter2
    import rv32i_types::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_next_o
);

    logic [1:0] cur;

    assign cur = ctr_i;

    always_comb begin
        ctr_next_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != STRONG_T) ctr_next_o = ctr_e'(2'(cur + 2'd1));
        end else begin
            if (ctr_i != STRONG_NT) ctr_next_o = ctr_e'(2'(cur - 2'd1));
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
//   clk, rst              : clock, synchronous active-high reset
//   fetch_pc              : IF-stage PC; pred_hit/pred_taken/pred_target are combinational
//   upd_valid/pc/taken/target : EX-stage resolution, written on the rising edge
//   flush                 : invalidate all entries (wins over an update in the same cycle)
//   mispredict            : combinational, stored prediction for upd_pc disagrees with outcome
// Optional: define BTB_STATS_EN to add stat_updates / stat_mispredicts (32-bit saturating).
module btb_predictor
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            flush,
    output logic            mispredict
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    btb_entry_t entries_q [DEPTH];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    btb_entry_t       u_ent, entry_d;
    logic             f_hit, u_hit, u_pred_taken, u_write;
    ctr_e             u_ctr_next;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[XLEN-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX_W+2];

    // Fetch-side lookup: reads pre-update state, so same-index updates are not forwarded
    assign f_hit       = entries_q[f_idx].valid && (entries_q[f_idx].tag == TAG_MAX'(f_tag));
    assign pred_hit    = f_hit;
    assign pred_taken  = f_hit && entries_q[f_idx].ctr[1];
    assign pred_target = pred_taken ? XLEN'(entries_q[f_idx].target) : fetch_pc + XLEN'(4);

    // Update-side lookup; a miss counts as predicted not-taken
    assign u_ent        = entries_q[u_idx];
    assign u_hit        = u_ent.valid && (u_ent.tag == TAG_MAX'(u_tag));
    assign u_pred_taken = u_hit && u_ent.ctr[1];
    assign mispredict   = upd_valid &&
                          ((u_pred_taken != upd_taken) ||
                           (u_pred_taken && upd_taken && (XLEN'(u_ent.target) != upd_target)));

    sat_counter2 u_ctr (
        .ctr_i      (u_ent.ctr),
        .taken_i    (upd_taken),
        .ctr_next_o (u_ctr_next)
    );

    // Not-taken misses leave the table untouched
    assign u_write = upd_valid && (u_hit || upd_taken);

    always_comb begin
        entry_d = u_ent;
        if (u_hit) begin
            entry_d.ctr = u_ctr_next;
            if (upd_taken) entry_d.target = XLEN_MAX'({upd_target[XLEN-1:1], 1'b0});
        end else begin
            entry_d.valid  = 1'b1;
            entry_d.tag    = TAG_MAX'(u_tag);
            entry_d.target = XLEN_MAX'({upd_target[XLEN-1:1], 1'b0});
            entry_d.ctr    = WEAK_T;
        end
    end

    // Table state: reset > flush > update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
                entries_q[i].ctr   <= STRONG_NT;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else if (u_write) begin
            entries_q[u_idx] <= entry_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_upd_q, stat_upd_d;
    logic [31:0] stat_mp_q,  stat_mp_d;

    // Saturating event counters; flush cycles are not counted and do not clear them
    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mp_d  = stat_mp_q;
        if (!flush && upd_valid && (stat_upd_q != '1)) stat_upd_d = stat_upd_q + 32'd1;
        if (!flush && mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_upd_q <= '0;
            stat_mp_q  <= '0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_mp_q  <= stat_mp_d;
        end
    end

    assign stat_updates     = stat_upd_q;
    assign stat_mispredicts = stat_mp_q;
`endif

    // Byte-offset bits of upd_pc do not participate in lookup
    logic unused_ok;
    assign unused_ok = ^upd_pc[1:0];

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of entries, power of two, 4..1024.
REQ-002 SHALL have parameter XLEN, default 32, PC and target width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port fetch_pc  in  XLEN  IF-stage PC to predict.
REQ-006 SHALL have port pred_hit  out  1  valid entry with matching tag for fetch_pc.
REQ-007 SHALL have port pred_taken  out  1  predicted taken.
REQ-008 SHALL have port pred_target  out  XLEN  predicted next PC.
REQ-009 SHALL have port upd_valid  in  1  EX-stage resolved control transfer this cycle.
REQ-010 SHALL have port upd_pc  in  XLEN  PC of resolved instruction.
REQ-011 SHALL have port upd_taken  in  1  actual outcome.
REQ-012 SHALL have port upd_target  in  XLEN  actual target, bit 0 forced to 0 on store.
REQ-013 SHALL have port flush  in  1  invalidate all entries.
REQ-014 SHALL have port mispredict  out  1  combinational; upd_valid and stored prediction for upd_pc disagrees with outcome.

Function
REQ-015 SHALL index with IDX_W=log2(DEPTH), index=pc[IDX_W+1:2], tag=pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
REQ-016 SHALL store per entry: valid, tag, XLEN-bit target, 2-bit saturating counter.
REQ-017 SHALL compute pred_hit/pred_taken/pred_target combinationally from current state, zero-cycle latency.
REQ-018 SHALL drive pred_taken = pred_hit & ctr[1]; pred_target = stored target if pred_taken, else fetch_pc+4 (modulo 2^XLEN).
REQ-019 SHALL, on upd_valid with hit and upd_taken, increment ctr saturating at 2'b11 and overwrite target.
REQ-020 SHALL, on upd_valid with hit and not upd_taken, decrement ctr saturating at 2'b00; target unchanged.
REQ-021 SHALL, on upd_valid with miss and upd_taken, allocate: valid=1, tag, target, ctr=2'b10, replacing any prior occupant.
REQ-022 SHALL, on upd_valid with miss and not upd_taken, leave state unchanged.
REQ-023 SHALL assert mispredict when upd_valid and (stored predicted-taken != upd_taken, or both taken and stored target != upd_target); miss counts as predicted not-taken.
REQ-024 SHALL, on fetch_pc and upd_pc same index in one cycle, present pre-update state on pred_* outputs.
REQ-025 SHALL, on flush, clear all valid bits next edge; flush with upd_valid in same cycle: flush wins, update dropped.
REQ-026 SHALL ignore upd_* when upd_valid=0.

Reset
REQ-027 SHALL clear all valid bits and counters to 2'b00 on rst; targets/tags need not reset.
REQ-028 SHALL, after reset, drive pred_hit=0, pred_taken=0, pred_target=fetch_pc+4, mispredict=upd_valid&upd_taken.
REQ-029 SHALL give rst priority over flush and upd_valid; reset mid-update drops the update.

Configuration
REQ-030 SHALL, with BTB_STATS_EN defined, add outputs stat_updates and stat_mispredicts (32 bits each) counting upd_valid cycles and mispredict cycles, saturating at 2^32-1, cleared by rst only, not by flush, not incremented when flush or rst is high.
REQ-031 SHALL, without BTB_STATS_EN, omit those ports and counters entirely.

Structure
REQ-032 SHALL place the btb_entry_t struct (valid, tag, target, ctr) and counter encodings (STRONG_NT=00 .. STRONG_T=11) in rv32i_types.
REQ-033 SHALL factor the 2-bit counter next-state logic into sub-module sat_counter2.

Verification
REQ-034 SHALL cover: reset, fetch_pc=0x60 -> pred_hit=0, pred_taken=0, pred_target=0x64.
REQ-035 SHALL cover: upd pc=0x100 taken target=0x200, next cycle fetch_pc=0x100 -> hit=1, taken=1, target=0x200, ctr=10.
REQ-036 SHALL cover: three more taken updates at 0x100 -> ctr=11 saturated; then two not-taken -> ctr=01, fetch 0x100 -> taken=0, target=0x104.
REQ-037 SHALL cover: DEPTH=64, allocate 0x100 then 0x200 (same index, different tag) -> fetch 0x100 misses, 0x200 hits.
REQ-038 SHALL cover: flush and upd_valid(0x300 taken) same cycle -> next cycle fetch 0x300 and 0x200 both miss.
REQ-039 SHALL cover: BTB_STATS_EN, 5 updates with 2 mispredicts -> stat_updates=5, stat_mispredicts=2; flush leaves both unchanged.
